// File: rtl/video_fetch_arbiter.sv
// video_fetch_arbiter: shares one synchronous RAM between a CPU and a video
// burst fetcher. The CPU owns the RAM until a video burst is accepted; the CPU
// is then asked to hold, and once it reports parked (and is not mid-write) the
// arbiter issues vid_len consecutive read addresses and streams the words out.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cpu_address/data_out  CPU address and write data (passed to RAM when CPU owns it)
//   cpu_write             CPU write strobe
//   cpu_data_in           RAM read data back to CPU (always ram_dout)
//   cpu_hold              registered stall request to CPU
//   cpu_busy              CPU acknowledges it is parked
//   vid_req/addr/len      video burst request, start address, word count
//   vid_data/valid/done   fetched word, word strobe, end-of-burst pulse
//   ram_addr/din/we/dout  synchronous RAM port (read data one cycle after address)
module video_fetch_arbiter #(
    parameter int unsigned BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_write,
    output logic [15:0] cpu_data_in,
    output logic        cpu_hold,
    input  logic        cpu_busy,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    input  logic [4:0]  vid_len,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        vid_done,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout
);

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        BURST     = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  ptr;
    logic [LW-1:0]  count;
    logic           hold_q;
    logic           valid_q;
    logic           done_q;
    logic           accept;
    logic           last_fetch;

    // A request is only taken in IDLE and only with a legal length.
    assign accept     = (state == IDLE) && vid_req && (vid_len != LW'(0))
                        && (32'(vid_len) <= BURST_MAX);
    assign last_fetch = (state == BURST) && (count == LW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD_WAIT;
                end
            end
            HOLD_WAIT: begin
                // A CPU write still in flight keeps the bus with the CPU.
                if (cpu_busy && !cpu_write) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (count == LW'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fetch pointer, remaining count and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            count   <= '0;
            hold_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hold_q  <= (state_next != IDLE);
            // Each BURST address returns data on the following cycle.
            valid_q <= (state == BURST);
            done_q  <= last_fetch;
            if (accept) begin
                ptr   <= vid_addr;
                count <= vid_len;
            end else if (state == BURST) begin
                ptr   <= ptr + AW'(1);
                count <= count - LW'(1);
            end
        end
    end

    // RAM port mux: CPU pass-through unless the fetcher owns the bus.
    always_comb begin
        ram_addr = cpu_address;
        ram_din  = cpu_data_out;
        ram_we   = cpu_write;
        if (!reset && ((state == BURST) || (state == DRAIN))) begin
            ram_addr = ptr;
            ram_we   = 1'b0;
        end
    end

    assign cpu_data_in = ram_dout;
    assign vid_data    = ram_dout;
    assign cpu_hold    = hold_q;
    assign vid_valid   = valid_q;
    assign vid_done    = done_q;

endmodule

// File: doc/video_fetch_arbiter.md
VIDEO_FETCH_ARBITER -- requirements
Module: video_fetch_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, giving the maximum words per video burst (vid_len 1..BURST_MAX).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cpu_address, input, 16, CPU bus address.
REQ-005 SHALL have port cpu_data_out, input, 16, CPU write data.
REQ-006 SHALL have port cpu_write, input, 1, CPU write strobe.
REQ-007 SHALL have port cpu_data_in, output, 16, read data to CPU.
REQ-008 SHALL have port cpu_hold, output, 1, stall request to CPU.
REQ-009 SHALL have port cpu_busy, input, 1, CPU acknowledgement that it is parked.
REQ-010 SHALL have port vid_req, input, 1, video burst request, level, sampled in IDLE only.
REQ-011 SHALL have port vid_addr, input, 16, burst start address, sampled with vid_req.
REQ-012 SHALL have port vid_len, input, 5, burst word count, sampled with vid_req.
REQ-013 SHALL have ports vid_data (output, 16), vid_valid (output, 1), vid_done (output, 1): fetched word, word strobe, one-cycle end-of-burst pulse.
REQ-014 SHALL have ports ram_addr (output, 16), ram_din (output, 16), ram_we (output, 1), ram_dout (input, 16): synchronous RAM, read data valid one cycle after address.

Function
REQ-015 SHALL implement states IDLE, HOLD_WAIT, BURST, DRAIN.
REQ-016 In IDLE and HOLD_WAIT, ram_addr/ram_din/ram_we SHALL combinationally follow cpu_address/cpu_data_out/cpu_write; cpu_data_in SHALL equal ram_dout in every state.
REQ-017 IDLE: vid_req=1 with vid_len in 1..BURST_MAX SHALL latch addr/len, assert cpu_hold, go HOLD_WAIT; vid_len=0 or >BURST_MAX SHALL be ignored (stay IDLE, no done pulse).
REQ-018 HOLD_WAIT: cpu_busy=1 and cpu_write=0 in the same cycle SHALL move to BURST; otherwise remain, cpu_hold held high, no timeout.
REQ-019 BURST: ram_we SHALL be 0, ram_addr SHALL be the internal fetch pointer, pointer increments by 1 per cycle, wrapping 0xFFFF -> 0x0000.
REQ-020 BURST SHALL issue exactly vid_len addresses on consecutive cycles, then move to DRAIN.
REQ-021 vid_valid SHALL assert exactly one cycle after each BURST address, with vid_data = ram_dout; valid words SHALL be contiguous, total vid_len.
REQ-022 DRAIN (one cycle) SHALL present the last word, pulse vid_done concurrently with it, deassert cpu_hold, return to IDLE.
REQ-023 cpu_hold SHALL be a registered output: 1 from the cycle after acceptance through DRAIN, 0 otherwise.
REQ-024 vid_req asserted in HOLD_WAIT, BURST or DRAIN SHALL be ignored; a still-high vid_req SHALL be accepted in the first IDLE cycle after DRAIN.
REQ-025 Latency: accept -> first vid_valid SHALL be (HOLD_WAIT cycles) + 2 cycles; last valid -> vid_done same cycle.

Reset
REQ-026 reset=1 at any posedge SHALL force IDLE, cpu_hold=0, vid_valid=0, vid_done=0, pointer and count 0, including mid-burst; no partial burst resumes.
REQ-027 During reset ram_we SHALL follow cpu_write (CPU pass-through), since the CPU drives write=0 in reset.

Verification
REQ-028 Bench: vid_req, vid_addr=0x1000, vid_len=4, cpu_busy high after 3 cycles -> ram_addr 0x1000..0x1003 on 4 consecutive cycles, 4 vid_valid with RAM contents, vid_done on 4th, cpu_hold low next cycle.
REQ-029 Bench: vid_addr=0xFFFE, vid_len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-030 Bench: CPU writes 0xBEEF to 0x0020 while HOLD_WAIT (cpu_busy=0) -> RAM location 0x0020 = 0xBEEF; no write during BURST.
REQ-031 Bench: reset asserted on 2nd BURST cycle of vid_len=8 -> next cycle IDLE, cpu_hold=0, no further vid_valid, no vid_done.
REQ-032 Bench: vid_len=0 and vid_len=17 requests -> cpu_hold stays 0, no vid_valid/vid_done; vid_req held high through a burst -> second burst starts the cycle after vid_done.
